// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  // Canonical bubble: addi x0, x0, 0.
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  // Which decode-resolved target wins when several are asserted together.
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_BR   = 2'd1,
    TGT_JAL  = 2'd2,
    TGT_JALR = 2'd3
  } redir_sel_e;

  // One buffered fetch result: the address it came from and the word itself.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Priority encode the redirect sources: jalr > jal > taken branch.
  function automatic redir_sel_e redirect_sel(input logic br_true,
                                              input logic jal_sel,
                                              input logic jalr_sel);
    if (jalr_sel)     return TGT_JALR;
    else if (jal_sel) return TGT_JAL;
    else if (br_true) return TGT_BR;
    else              return TGT_NONE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  // Fetch side issues requests and consumes in-order responses.
  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  // Memory side accepts requests and returns responses without backpressure.
  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with single-cycle flush; used for the instruction
// buffer and for the PC shadow queue of the fetch stage.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push_i & ~flush_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // Next pointer/occupancy; flush empties the queue in one cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers returning words and feeds pc_decode/instr_decode. Redirects from
// decode squash the decode registers, flush the buffer and kill every
// response still in flight.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic [XLEN-1:0]      br_decode,
  input  logic [XLEN-1:0]      jal_decode,
  input  logic [XLEN-1:0]      jalr_decode,
  input  logic                 br_true,
  input  logic                 jal_sel,
  input  logic                 jalr_sel,
  input  logic                 stall_fetch,
  output logic [XLEN-1:0]      pc_decode,
  output logic [XLEN-1:0]      instr_decode
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0]  pc_f_q, pc_f_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] kill_q, kill_d;
  logic [XLEN-1:0]  pc_dec_q, pc_dec_d;
  logic [XLEN-1:0]  instr_dec_q, instr_dec_d;

  redir_sel_e       sel;
  logic             redirect;
  logic [XLEN-1:0]  target_raw, target;
  logic [CNT_W:0]   credit_used;
  logic             credit_ok;
  logic             req_fire, rsp_fire, kill_active;

  fetch_pkt_t       buf_in, buf_head;
  logic             buf_push, buf_pop, buf_empty;
  logic [CNT_W-1:0] buf_cnt;
  logic [XLEN-1:0]  shadow_pc;
  logic [CNT_W-1:0] shadow_cnt;
  logic             shadow_empty;

  // Redirect is suppressed while decode is stalled; the target is word aligned.
  assign sel      = redirect_sel(br_true, jal_sel, jalr_sel);
  assign redirect = (sel != TGT_NONE) & ~stall_fetch;
  assign target   = target_raw & ~XLEN'(3);

  // Select the winning redirect target.
  always_comb begin
    target_raw = br_decode;
    unique case (sel)
      TGT_JALR: target_raw = jalr_decode;
      TGT_JAL:  target_raw = jal_decode;
      TGT_BR:   target_raw = br_decode;
      TGT_NONE: target_raw = br_decode;
    endcase
  end

  // Credit covers both in-flight requests and buffered words, so the buffer
  // can never overflow. Held low in reset so nothing escapes while cleared.
  assign credit_used    = {1'b0, outst_q} + {1'b0, buf_cnt};
  assign credit_ok      = credit_used < (CNT_W + 1)'(MAX_OUTST);
  assign imem.req_valid = rst_n & ~redirect & credit_ok;
  assign imem.req_addr  = pc_f_q;
  assign req_fire       = imem.req_valid & imem.req_ready;
  assign rsp_fire       = imem.rsp_valid;
  assign kill_active    = (kill_q != '0);

  // Wrong-path words (pending kills or arriving in a redirect cycle) are dropped.
  assign buf_push = rsp_fire & ~kill_active & ~redirect;
  assign buf_pop  = ~stall_fetch & ~redirect & ~buf_empty;
  assign buf_in   = '{pc: shadow_pc, instr: imem.rsp_data};

  // PC of every issued request, retired by its response whether kept or killed.
  fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(XLEN)) u_pc_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .pop_i   (rsp_fire),
    .flush_i (1'b0),
    .data_i  (pc_f_q),
    .data_o  (shadow_pc),
    .count_o (shadow_cnt),
    .empty_o (shadow_empty)
  );

  // Returned {pc, instr} pairs waiting for decode.
  fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(2 * XLEN)) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (redirect),
    .data_i  (buf_in),
    .data_o  (buf_head),
    .count_o (buf_cnt),
    .empty_o (buf_empty)
  );

  // Next PC, in-flight/kill counters and decode registers.
  always_comb begin
    pc_f_d      = pc_f_q;
    outst_d     = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    kill_d      = kill_q;
    pc_dec_d    = pc_dec_q;
    instr_dec_d = instr_dec_q;

    if (redirect) begin
      pc_f_d = target;
      // Everything still outstanding after this cycle belongs to the old path.
      kill_d = outst_q - CNT_W'(rsp_fire);
    end else begin
      if (req_fire)                pc_f_d = pc_f_q + XLEN'(4);
      if (rsp_fire && kill_active) kill_d = kill_q - 1'b1;
    end

    if (!stall_fetch) begin
      if (redirect || buf_empty) begin
        pc_dec_d    = '0;
        instr_dec_d = NOP_INSTR;
      end else begin
        pc_dec_d    = buf_head.pc;
        instr_dec_d = buf_head.instr;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q      <= RESET_PC;
      outst_q     <= '0;
      kill_q      <= '0;
      pc_dec_q    <= '0;
      instr_dec_q <= NOP_INSTR;
    end else begin
      pc_f_q      <= pc_f_d;
      outst_q     <= outst_d;
      kill_q      <= kill_d;
      pc_dec_q    <= pc_dec_d;
      instr_dec_q <= instr_dec_d;
    end
  end

  assign pc_decode    = pc_dec_q;
  assign instr_decode = instr_dec_q;

  // A response with nothing outstanding is a memory protocol error.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem.rsp_valid |-> (outst_q != '0) && !shadow_empty);

  // The PC shadow queue must track the outstanding count exactly.
  a_shadow_sync: assert property (@(posedge clk) disable iff (!rst_n)
    shadow_cnt == outst_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed phases followed by random traffic, checked
// against a stream-level model (epoch tagged in-flight queue, expected PC stream).
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int              MAX_OUTST = 2;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP       = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] br_decode, jal_decode, jalr_decode;
  logic            br_true, jal_sel, jalr_sel, stall_fetch;
  logic [XLEN-1:0] pc_decode, instr_decode;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .br_decode    (br_decode),
    .jal_decode   (jal_decode),
    .jalr_decode  (jalr_decode),
    .br_true      (br_true),
    .jal_sel      (jal_sel),
    .jalr_sel     (jalr_sel),
    .stall_fetch  (stall_fetch),
    .pc_decode    (pc_decode),
    .instr_decode (instr_decode)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              epoch;
    int              due;
  } mem_txn_t;

  mem_txn_t        mq[$];
  logic [XLEN-1:0] exp_fetch_pc, exp_stream_pc, exp_pc_dec, exp_instr_dec;
  int              epoch, good_rsp, delivered, now, last_due, lat_max;

  // Instruction memory contents; bit 7 set so no word ever equals the NOP.
  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h0000_0080;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_fetch_pc  = RESET_PC;
    exp_stream_pc = RESET_PC;
    exp_pc_dec    = '0;
    exp_instr_dec = NOP;
    epoch         = 0;
    good_rsp      = 0;
    delivered     = 0;
    last_due      = now;
  endtask

  // One clock cycle: called just after a falling edge, ends just after the next one.
  task automatic step(input logic stall, input logic b, input logic j, input logic jr,
                      input logic [XLEN-1:0] bt, input logic [XLEN-1:0] jt,
                      input logic [XLEN-1:0] jrt, input logic rdy);
    logic            redirect, rsp_now, fire, exp_valid;
    logic [XLEN-1:0] tgt;
    int              buffered, inflight, due;
    mem_txn_t        head;

    stall_fetch = stall;  br_true = b;  jal_sel = j;  jalr_sel = jr;
    br_decode = bt;  jal_decode = jt;  jalr_decode = jrt;
    imem.req_ready = rdy;
    rsp_now        = (mq.size() > 0) && (mq[0].due <= now);
    imem.rsp_valid = rsp_now;
    imem.rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom;
    #1;

    redirect = (b | j | jr) & ~stall;
    tgt      = jr ? jrt : (j ? jt : bt);
    tgt      = tgt & ~32'h3;
    inflight = mq.size();
    buffered = good_rsp - delivered;

    exp_valid = !redirect && (inflight + buffered < MAX_OUTST);
    check("req_valid", {31'b0, imem.req_valid}, {31'b0, exp_valid});
    fire = imem.req_valid && rdy;
    if (fire) check("req_addr", imem.req_addr, exp_fetch_pc);

    // Decode outcome of this edge, from state before this cycle's response.
    if (!stall) begin
      if (!redirect && buffered > 0) begin
        exp_pc_dec    = exp_stream_pc;
        exp_instr_dec = mem_word(exp_stream_pc);
        exp_stream_pc = exp_stream_pc + 32'd4;
        delivered++;
      end else begin
        exp_pc_dec    = '0;
        exp_instr_dec = NOP;
      end
    end

    if (rsp_now) begin
      head = mq.pop_front();
      if (head.epoch == epoch && !redirect) good_rsp++;
    end
    if (fire) begin
      due = now + $urandom_range(1, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem.req_addr, epoch: epoch, due: due});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redirect) begin
      epoch++;
      good_rsp      = 0;
      delivered     = 0;
      exp_fetch_pc  = tgt;
      exp_stream_pc = tgt;
    end

    now++;
    @(negedge clk);
    check("pc_decode", pc_decode, exp_pc_dec);
    check("instr_decode", instr_decode, exp_instr_dec);
  endtask

  task automatic idle(input int n, input logic stall, input logic rdy);
    for (int i = 0; i < n; i++) step(stall, 1'b0, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc_decode, 32'h0);
    check({tag, "_instr"}, instr_decode, NOP);
    check({tag, "_req_valid"}, {31'b0, imem.req_valid}, 32'h0);
  endtask

  initial begin
    logic [XLEN-1:0] t;
    now = 0;  lat_max = 1;
    stall_fetch = 1'b0;  br_true = 1'b0;  jal_sel = 1'b0;  jalr_sel = 1'b0;
    br_decode = '0;  jal_decode = '0;  jalr_decode = '0;
    imem.req_ready = 1'b0;  imem.rsp_valid = 1'b0;  imem.rsp_data = '0;
    model_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: always-ready single-cycle memory from RESET_PC.
    idle(12, 1'b0, 1'b1);

    // 2: memory not ready for 5 cycles, then resumes.
    idle(5, 1'b0, 1'b0);
    idle(6, 1'b0, 1'b1);

    // 3: jal to 0x100 with two requests in flight on a slower memory.
    lat_max = 3;
    idle(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0100, 32'h0, 1'b1);
    idle(10, 1'b0, 1'b1);
    lat_max = 1;

    // 4: decode stalled for 4 cycles, then released.
    idle(4, 1'b1, 1'b1);
    idle(8, 1'b0, 1'b1);

    // 5: branch and jalr together, held off by stall, then taken to 0x200.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'h0000_0203, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'h0000_0203, 1'b1);
    idle(6, 1'b0, 1'b1);

    // Wrap at top of memory.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF6, 32'h0, 32'h0, 1'b1);
    idle(10, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      lat_max = $urandom_range(1, 3);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
      step($urandom_range(0, 4) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 23) == 0,
           $urandom_range(0, 31) == 0,
           t, $urandom, $urandom,
           $urandom_range(0, 3) != 0);
    end

    // 6: reset pulsed mid-burst; outputs clear asynchronously, fetch restarts.
    lat_max = 2;
    idle(5, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    imem.rsp_valid = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    lat_max = 1;
    idle(15, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
